ca_correlator: RTL and testbench

Receive-side counterpart of the C/A code generator. Despreads 2-bit I/Q baseband samples against a locally generated GPS L1 C/A Gold code. Accumulates one full 1 ms code epoch of 1023 chips at a programmed code phase, then reports signed I and Q correlation sums. It sits between the sample front end (4-bit IQ words) and the acquisition/tracking control logic.

---
 rtl/ca_correlator.sv | 137 +++++++++++++
 tb/tb_ca_correlator.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ca_correlator.sv
// GPS L1 C/A correlator: despreads 2-bit I/Q samples against a local Gold code over one 1023-chip epoch.
// Optional CA_CORR_ENERGY_EN builds a registered i_acc^2 + q_acc^2 energy output.
module ca_correlator #(
   parameter int SPC   = 4,
   parameter int ACC_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [3:0]              t0,
   input  logic [3:0]              t1,
   input  logic [9:0]              code_phase,
   input  logic                    sample_valid,
   input  logic [1:0]              i_d,
   input  logic [1:0]              q_d,
   output logic                    busy,
   output logic                    done,
   output logic signed [ACC_W-1:0] i_acc,
   output logic signed [ACC_W-1:0] q_acc,
   output logic [2*ACC_W-1:0]      energy,
   output logic                    chip
);
   localparam int SW = (SPC > 1) ? $clog2(SPC) : 1;

   typedef enum logic [1:0] {IDLE, SKIP, ACCUM, DONE} state_t;

   state_t           state;
   logic [10:1]      g1, g2;
   logic [3:0]       t0_q, t1_q;
   logic [9:0]       ph_q, skip_cnt, chip_cnt;
   logic [SW-1:0]    samp_cnt;
   logic             code_chip, chip_end, last;
   logic [10:1]      g1_nx, g2_nx;
   logic signed [ACC_W-1:0] i_nx, q_nx;

   function automatic logic tap(input logic [10:1] g, input logic [3:0] t);
      if (t >= 4'd1 && t <= 4'd10) return g[t];
      return 1'b0;
   endfunction

   // Sample value (+-1/+-3) multiplied by the chip sign (chip 1 -> -1).
   function automatic logic signed [ACC_W-1:0] term(input logic [1:0] d, input logic c);
      logic signed [ACC_W-1:0] m;
      m = d[0] ? ACC_W'(3) : ACC_W'(1);
      return (d[1] ^ c) ? -m : m;
   endfunction

   assign code_chip = g1[10] ^ tap(g2, t0_q) ^ tap(g2, t1_q);
   assign g1_nx     = {g1[9:1], g1[3] ^ g1[10]};
   assign g2_nx     = {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
   assign i_nx      = i_acc + term(i_d, code_chip);
   assign q_nx      = q_acc + term(q_d, code_chip);
   assign chip_end  = (samp_cnt == SW'(SPC - 1));
   assign last      = (state == ACCUM) && sample_valid && chip_end && (chip_cnt == 10'd1022);
   // Debug chip reads 0 outside SKIP/ACCUM so the idle value is deterministic.
   assign chip      = busy & code_chip;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         i_acc    <= '0;
         q_acc    <= '0;
         g1       <= '1;
         g2       <= '1;
         t0_q     <= '0;
         t1_q     <= '0;
         ph_q     <= '0;
         skip_cnt <= '0;
         chip_cnt <= '0;
         samp_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               t0_q     <= t0;
               t1_q     <= t1;
               ph_q     <= code_phase;
               g1       <= '1;
               g2       <= '1;
               i_acc    <= '0;
               q_acc    <= '0;
               skip_cnt <= '0;
               chip_cnt <= '0;
               samp_cnt <= '0;
               busy     <= 1'b1;
               state    <= (code_phase == 10'd0 || code_phase == 10'd1023) ? ACCUM : SKIP;
            end
            SKIP: begin
               g1       <= g1_nx;
               g2       <= g2_nx;
               skip_cnt <= skip_cnt + 10'd1;
               if (skip_cnt == ph_q - 10'd1) state <= ACCUM;
            end
            ACCUM: if (sample_valid) begin
               i_acc <= i_nx;
               q_acc <= q_nx;
               if (chip_end) begin
                  samp_cnt <= '0;
                  g1       <= g1_nx;
                  g2       <= g2_nx;
                  if (chip_cnt == 10'd1022) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     chip_cnt <= chip_cnt + 10'd1;
                  end
               end else begin
                  samp_cnt <= samp_cnt + SW'(1);
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CA_CORR_ENERGY_EN
   function automatic logic [2*ACC_W-1:0] sq(input logic signed [ACC_W-1:0] v);
      logic signed [2*ACC_W-1:0] x;
      x = {{ACC_W{v[ACC_W-1]}}, v};
      return x * x;
   endfunction

   // Squares the post-add sums on the final accept edge so energy lands with done.
   always_ff @(posedge clk) begin
      if (rst)                        energy <= '0;
      else if (state == IDLE && start) energy <= '0;
      else if (last)                  energy <= sq(i_nx) + sq(q_nx);
   end
`else
   assign energy = '0;
`endif

endmodule

// File: tb/tb_ca_correlator.sv
// Directed bench for ca_correlator: sequence-level code model, per-cycle compare process, literal pins.
module tb_ca_correlator;
   localparam int SPC   = 4;
   localparam int ACC_W = 16;
   localparam int NS    = 1023 * SPC;

   logic                    clk = 1'b0;
   logic                    rst, start, sample_valid;
   logic [3:0]              t0, t1;
   logic [9:0]              code_phase;
   logic [1:0]              i_d, q_d;
   logic                    busy, done, chip;
   logic signed [ACC_W-1:0] i_acc, q_acc;
   logic [2*ACC_W-1:0]      energy;

   ca_correlator #(.SPC(SPC), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst), .start(start), .t0(t0), .t1(t1), .code_phase(code_phase),
      .sample_valid(sample_valid), .i_d(i_d), .q_d(q_d), .busy(busy), .done(done),
      .i_acc(i_acc), .q_acc(q_acc), .energy(energy), .chip(chip));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int code [0:1022];
   bit per_ok;
   // expectations for the cycle following the next rising edge
   bit e_busy, e_done, e_chk_acc, e_chk_chip, e_chk_en, e_chip;
   longint e_i, e_q, e_en, exp_i, exp_q;
   longint res_i, res_q, res_en;
   int cyc = 0, t_busy = 0, t_done = 0;
   bit busy_d = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Gold code as sequences: a[n] = a[n-3]^a[n-10], stage i at time n holds a[n-i].
   task automatic build_code(input int ta, input int tb);
      bit a [0:1032];
      bit b [0:1032];
      for (int n = 0; n < 10; n++) begin a[n] = 1'b1; b[n] = 1'b1; end
      for (int n = 0; n < 1023; n++) begin
         a[n+10] = a[n+7] ^ a[n];
         b[n+10] = b[n+8] ^ b[n+7] ^ b[n+4] ^ b[n+2] ^ b[n+1] ^ b[n];
         code[n] = a[n] ^ b[n+10-ta] ^ b[n+10-tb];
      end
      per_ok = 1'b1;
      for (int n = 1023; n <= 1032; n++) if (!a[n] || !b[n]) per_ok = 1'b0;
   endtask

   function automatic longint sval(input logic [1:0] d);
      return (d[0] ? 3 : 1) * (d[1] ? -1 : 1);
   endfunction

   function automatic longint model_energy(input longint i, input longint q);
`ifdef CA_CORR_ENERGY_EN
      return i * i + q * q;
`else
      return 0 * (i + q);
`endif
   endfunction

   always @(posedge clk) begin
      #1;
      cyc++;
      if (busy && !busy_d) t_busy = cyc;
      if (done) t_done = cyc;
      busy_d = busy;
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      if (e_chk_chip) chk("chip", chip, e_chip);
      if (e_chk_acc) begin
         chk("i_acc", i_acc, e_i);
         chk("q_acc", q_acc, e_q);
      end
      if (e_chk_en) chk("energy", energy, e_en);
   end

   task automatic set_idle(input longint i, input longint q, input bit en_chk);
      e_busy = 0; e_done = 0; e_chk_chip = 1; e_chip = 0;
      e_chk_acc = 1; e_i = i; e_q = q; e_chk_en = en_chk; e_en = 0;
   endtask

   task automatic do_abort;
      rst = 1; start = 0; sample_valid = 1;
      set_idle(0, 0, 1);
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         sample_valid = j[0]; i_d = 2'($urandom); q_d = 2'($urandom);
      end
      @(negedge clk);
   endtask

   // mode 0: i_d = {received chip, 1}, q_d = 00 with received code at phase 0; mode 1: random samples
   task automatic run_epoch(input int ta, input int tb, input int ph, input int mode,
                            input bit gap, input bit stray, input int abort_at);
      int eff, k, m;
      bit v;
      logic [1:0] si, sq;
      build_code(ta, tb);
      eff = (ph == 1023) ? 0 : ph;
      @(negedge clk);
      start = 1; t0 = 4'(ta); t1 = 4'(tb); code_phase = 10'(ph);
      sample_valid = 1'($urandom); i_d = 2'($urandom); q_d = 2'($urandom);
      exp_i = 0; exp_q = 0;
      e_busy = 1; e_done = 0; e_chk_acc = 1; e_i = 0; e_q = 0;
      e_chk_chip = 1; e_chip = code[0][0]; e_chk_en = 0;
      for (m = 1; m <= eff; m++) begin
         @(negedge clk);
         start = stray && (m == 1);
         t0 = 4'($urandom_range(1, 10)); t1 = 4'($urandom_range(1, 10));
         code_phase = 10'($urandom);
         sample_valid = 1; i_d = 2'($urandom); q_d = 2'($urandom);
         e_chk_acc = 0; e_chip = code[m][0];
      end
      k = 0; m = 0;
      while (k < NS) begin
         @(negedge clk);
         if (abort_at > 0 && k == abort_at) begin
            do_abort;
            return;
         end
         start = stray && (m == 5);
         m++;
         e_chk_acc = 0;
         v = gap ? (m % 2 == 1) : 1'b1;
         if (mode == 0) begin si = {code[k/SPC][0], 1'b1}; sq = 2'b00; end
         else begin si = 2'($urandom); sq = 2'($urandom); end
         sample_valid = v; i_d = si; q_d = sq;
         if (v) begin
            exp_i += sval(si) * (code[(eff + k/SPC) % 1023] ? -1 : 1);
            exp_q += sval(sq) * (code[(eff + k/SPC) % 1023] ? -1 : 1);
            k++;
         end
         if (k == NS) begin
            e_busy = 0; e_done = 1; e_chk_acc = 1; e_i = exp_i; e_q = exp_q;
            e_chip = 0; e_chk_en = 1; e_en = model_energy(exp_i, exp_q);
         end else begin
            e_chip = code[(eff + k/SPC) % 1023][0];
         end
      end
      @(negedge clk);
      res_i = i_acc; res_q = q_acc; res_en = longint'(energy);
      start = stray; sample_valid = 1; i_d = 2'($urandom); q_d = 2'($urandom);
      set_idle(exp_i, exp_q, 0);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         start = 0;
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit [9:0] pat;
      longint lat;
      rst = 1; start = 0; t0 = 4'd2; t1 = 4'd6; code_phase = '0;
      sample_valid = 0; i_d = '0; q_d = '0;
      set_idle(0, 0, 1);
      repeat (2) @(negedge clk);
      rst = 0;

      // model pins: PRN1 first ten chips and LFSR period
      build_code(2, 6);
      pat = 10'b1100100000;
      for (int i = 0; i < 10; i++) chk("code_pin", code[i], pat[9-i]);
      chk("code_period", per_ok, 1);

      run_epoch(2, 6, 0, 0, 0, 0, 0);
      chk("aligned_i", res_i, 12276);
      chk("aligned_q", res_q, -4);
      lat = t_done - t_busy;
      chk("aligned_latency", lat, 4092);
`ifdef CA_CORR_ENERGY_EN
      chk("aligned_energy", res_en, 150700192);
`else
      chk("aligned_energy", res_en, 0);
`endif

      run_epoch(2, 6, 0, 1, 0, 0, 1500);

      run_epoch(2, 6, 1, 0, 0, 0, 0);
      chk("misaligned_bound", (res_i <= 780 && res_i >= -780), 1);

      run_epoch(2, 6, 0, 0, 1, 0, 0);
      chk("gapped_i", res_i, 12276);
      chk("gapped_q", res_q, -4);

      run_epoch(2, 6, 1023, 0, 0, 1, 0);
      chk("phase1023_i", res_i, 12276);
      chk("phase1023_q", res_q, -4);

      run_epoch(3, 7, 1022, 1, 0, 1, 0);
      run_epoch(5, 9, 37, 1, 1, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
